// File: rtl/tristate_responder_if.sv
// Bundle of shared-pin pad signals and the request/response side bus of the responder.
interface tristate_responder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             line_in;
    logic             z_state;
    logic             line_out;
    logic             line_oe;
    logic [WIDTH-1:0] req_data;
    logic             req_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             err;
    logic             busy;

    // Responder side
    modport slave (
        input  line_in, z_state, rsp_data, rsp_valid,
        output line_out, line_oe, req_data, req_valid, rsp_ready, err, busy
    );

    // Pad / host side
    modport master (
        output line_in, z_state, rsp_data, rsp_valid,
        input  line_out, line_oe, req_data, req_valid, rsp_ready, err, busy
    );
endinterface

// File: rtl/tristate_responder.sv
// Far-end responder of a single-wire half-duplex link: receives a request frame,
// waits a turnaround gap after the initiator releases the pin, then drives back
// a buffered response frame (start 0, data LSB first, stop 1).
module tristate_responder #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TURNAROUND = 2
) (
    input logic                 clk,
    input logic                 rst,
    tristate_responder_if.slave bus
);

    // One counter serves RX bit index, TURN gap and TX bit index
    localparam int unsigned CNT_W = ($clog2(WIDTH + 2) > 4) ? $clog2(WIDTH + 2) : 4;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_WAIT_REL,
        S_TURN,
        S_TX
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_req_data;
    logic             r_req_valid;
    logic [WIDTH-1:0] r_buf;
    logic             r_rsp_ready;
    logic             r_line_out;
    logic             r_line_oe;
    logic             r_err;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_req_data_nxt;
    logic             w_req_valid_nxt;
    logic [WIDTH-1:0] w_buf_nxt;
    logic             w_rsp_ready_nxt;
    logic             w_line_out_nxt;
    logic             w_line_oe_nxt;
    logic             w_err_nxt;
    logic             w_load;
    logic [IDX_W-1:0] w_bit_idx;

    assign w_load    = bus.rsp_valid && r_rsp_ready;
    assign w_bit_idx = IDX_W'(r_cnt);

    // State and registered outputs; reset releases the pin without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_req_data  <= '0;
            r_req_valid <= 1'b0;
            r_buf       <= '0;
            r_rsp_ready <= 1'b1;
            r_line_out  <= 1'b1;
            r_line_oe   <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_req_data  <= w_req_data_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_buf       <= w_buf_nxt;
            r_rsp_ready <= w_rsp_ready_nxt;
            r_line_out  <= w_line_out_nxt;
            r_line_oe   <= w_line_oe_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_req_data_nxt  = r_req_data;
        w_req_valid_nxt = 1'b0;
        w_buf_nxt       = w_load ? bus.rsp_data : r_buf;
        w_rsp_ready_nxt = r_rsp_ready && !w_load;
        w_line_out_nxt  = 1'b1;
        w_line_oe_nxt   = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A driven low level is the start bit; a driven high level is ignored
                if (!bus.z_state && !bus.line_in) begin
                    w_state_nxt = S_RX;
                    w_cnt_nxt   = '0;
                end
            end

            S_RX: begin
                if (bus.z_state) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_shift_nxt = (r_shift >> 1) | (WIDTH'(bus.line_in) << (WIDTH - 1));
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_req_data_nxt  = w_shift_nxt;
                        w_req_valid_nxt = 1'b1;
                        w_state_nxt     = S_WAIT_REL;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            S_WAIT_REL: begin
                if (bus.z_state) begin
                    w_state_nxt = S_TURN;
                    w_cnt_nxt   = '0;
                end
            end

            S_TURN: begin
                // Anyone driving during the gap aborts; the buffered response survives
                if (!bus.z_state) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(TURNAROUND - 1)) begin
                    if (!r_rsp_ready || w_load) begin
                        w_state_nxt    = S_TX;
                        w_cnt_nxt      = '0;
                        w_line_oe_nxt  = 1'b1;
                        w_line_out_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_TX: begin
                // r_cnt is the index of the bit currently on the pin (0 = start bit)
                if ((r_cnt != '0) && (bus.line_in != r_line_out)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(WIDTH + 1)) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                    w_line_oe_nxt  = 1'b1;
                    w_line_out_nxt = (r_cnt == CNT_W'(WIDTH)) ? 1'b1 : r_buf[w_bit_idx];
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.line_out  = r_line_out;
    assign bus.line_oe   = r_line_oe;
    assign bus.req_data  = r_req_data;
    assign bus.req_valid = r_req_valid;
    assign bus.rsp_ready = r_rsp_ready;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_tristate_responder.sv
// Scoreboard bench for tristate_responder: stimulus pushes expected requests,
// error pulses and response frames; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_tristate_responder;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned TURNAROUND = 2;
    localparam int unsigned FLEN       = WIDTH + 2;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic drv_en    = 1'b0;
    logic drv_val   = 1'b1;
    logic force_col = 1'b0;

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int err_pend    = 0;
    int last_req    = 0;

    logic [WIDTH-1:0] req_q[$];
    logic [FLEN-1:0]  frm_q[$];

    tristate_responder_if #(.WIDTH(WIDTH)) bus ();

    // Pin model: responder drive wins, else initiator drive, else pull-up; force_col pulls low
    assign bus.line_in = force_col ? 1'b0 :
                         (bus.line_oe ? bus.line_out : (drv_en ? drv_val : 1'b1));
    assign bus.z_state = !(bus.line_oe || drv_en);

    tristate_responder #(.WIDTH(WIDTH), .TURNAROUND(TURNAROUND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 ns after each rising edge
    logic            capt  = 1'b0;
    int              flen  = 0;
    logic [FLEN-1:0] fbits = '0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            capt = 1'b0;
        end else begin
            if (!bus.line_oe) check("idle_level", 32'(bus.line_out), 32'd1);
            if (bus.req_valid) begin
                if (req_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_req: got 0x%0h expected none", bus.req_data);
                end else begin
                    check("req_data", 32'(bus.req_data), 32'(req_q.pop_front()));
                end
                last_req = cyc;
            end
            if (bus.err) begin
                check("err_expected", 32'(err_pend > 0), 32'd1);
                if (err_pend > 0) err_pend--;
            end
            if (bus.line_oe) begin
                if (!capt) begin
                    capt  = 1'b1;
                    flen  = 0;
                    fbits = '0;
                    check("turn_gap", 32'(cyc - last_req), 32'(TURNAROUND + 1));
                end
                if (flen < int'(FLEN)) fbits[flen] = bus.line_out;
                flen++;
            end else if (capt) begin
                capt = 1'b0;
                check("frame_len", 32'(flen), 32'(FLEN));
                if (frm_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_frame: got 0x%0h expected none", fbits);
                end else begin
                    check("frame_bits", 32'(fbits), 32'(frm_q.pop_front()));
                end
            end
        end
    end

    task automatic load_rsp(input logic [WIDTH-1:0] d);
        @(negedge clk); bus.rsp_valid = 1'b1; bus.rsp_data = d;
        @(negedge clk); bus.rsp_valid = 1'b0;
    endtask

    // Start bit, nbits data bits LSB first, then release the pin
    task automatic send_req(input logic [WIDTH-1:0] d, input int nbits);
        @(negedge clk); drv_en = 1'b1; drv_val = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); drv_val = d[i];
        end
        @(negedge clk); drv_en = 1'b0; drv_val = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.line_oe) && n < 100) begin
            @(negedge clk); n++;
        end
        check(name, 32'(n < 100), 32'd1);
    endtask

    task automatic wait_oe(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.line_oe && n < 50) begin
            @(negedge clk); n++;
        end
        check(name, 32'(n < 50), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state with the pin idle
        repeat (10) @(negedge clk);
        check("rst_oe",        32'(bus.line_oe),   32'd0);
        check("rst_line_out",  32'(bus.line_out),  32'd1);
        check("rst_rsp_ready", 32'(bus.rsp_ready), 32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_req_data",  32'(bus.req_data),  32'd0);

        // Driven-high pin is not a start bit
        @(negedge clk); drv_en = 1'b1; drv_val = 1'b1;
        repeat (3) @(negedge clk);
        check("no_start_busy", 32'(bus.busy), 32'd0);
        drv_en = 1'b0;

        // Full exchange: request 0xA5, response 0x3C
        load_rsp(8'h3C);
        check("ready_after_load", 32'(bus.rsp_ready), 32'd0);
        req_q.push_back(8'hA5);
        frm_q.push_back(10'b1001111000);
        send_req(8'hA5, 8);
        wait_idle("tx_done");
        check("ready_after_tx", 32'(bus.rsp_ready), 32'd1);

        // No response loaded: silent NAK
        req_q.push_back(8'hA5);
        send_req(8'hA5, 8);
        wait_idle("nak_done");
        check("nak_ready", 32'(bus.rsp_ready), 32'd1);

        // Abort after 4 data bits
        err_pend++;
        send_req(8'hFF, 4);
        @(negedge clk);
        check("abort_busy",     32'(bus.busy),     32'd0);
        check("abort_req_data", 32'(bus.req_data), 32'hA5);

        // Response loaded on the last TURN cycle still goes out
        req_q.push_back(8'h18);
        frm_q.push_back(10'b1100000010);
        send_req(8'h18, 8);
        @(negedge clk);
        @(negedge clk); bus.rsp_valid = 1'b1; bus.rsp_data = 8'h81;
        @(negedge clk); bus.rsp_valid = 1'b0;
        wait_idle("late_load_done");
        check("late_load_ready", 32'(bus.rsp_ready), 32'd1);

        // Collision on the stop bit keeps the buffer
        load_rsp(8'h3C);
        req_q.push_back(8'h5A);
        frm_q.push_back(10'b1001111000);
        err_pend++;
        send_req(8'h5A, 8);
        wait_oe("col_oe_rise");
        repeat (9) @(negedge clk);
        force_col = 1'b1;
        @(negedge clk);
        force_col = 1'b0;
        check("col_oe",    32'(bus.line_oe),   32'd0);
        check("col_ready", 32'(bus.rsp_ready), 32'd0);
        check("col_busy",  32'(bus.busy),      32'd0);

        // Next request re-sends the kept response
        req_q.push_back(8'h42);
        frm_q.push_back(10'b1001111000);
        send_req(8'h42, 8);
        wait_idle("resend_done");
        check("resend_ready", 32'(bus.rsp_ready), 32'd1);

        // Reset in the middle of TX releases the pin without a clock edge
        load_rsp(8'h3C);
        req_q.push_back(8'h99);
        send_req(8'h99, 8);
        wait_oe("rst_oe_rise");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_oe",  32'(bus.line_oe),  32'd0);
        check("rst_async_out", 32'(bus.line_out), 32'd1);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_ready", 32'(bus.rsp_ready), 32'd1);
        check("post_rst_busy",  32'(bus.busy),      32'd0);
        check("post_rst_oe",    32'(bus.line_oe),   32'd0);

        repeat (5) @(negedge clk);
        check("req_q_empty", 32'(req_q.size()), 32'd0);
        check("frm_q_empty", 32'(frm_q.size()), 32'd0);
        check("err_drained", 32'(err_pend),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tristate_responder.md
Name: tristate_responder

Overview:
- Far end of a single-wire, half-duplex tri-state link.
- Receives a request frame that the initiator drives onto the shared pin, then releases the line.
- Waits a turnaround gap, then drives a buffered response frame back on the same pin before releasing it again.
- Sits beside the pad cell; the pad reports the sampled level and a high-Z indication.

Parameters:
- WIDTH, 8, data bits per frame (1..32).
- TURNAROUND, 2, idle cycles between initiator release and responder start bit (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- line_in  in  1  sampled level of the shared pin.
- z_state  in  1  1 = pin undriven (high-Z), from the pad.
- line_out  out  1  value to drive on the pin.
- line_oe  out  1  output enable; pin is driven only when 1.
- req_data  out  WIDTH  last received request word.
- req_valid  out  1  one-cycle pulse, req_data valid.
- rsp_data  in  WIDTH  response word to load.
- rsp_valid  in  1  response offered.
- rsp_ready  out  1  response buffer empty.
- err  out  1  one-cycle pulse on frame abort or collision.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: outputs registered; all cleared to 0 except line_out=1 and rsp_ready=1; state IDLE; buffer empty.
- Reset mid-frame: line_oe drops asynchronously, so the pin is released immediately.
- Response buffer: one entry. A load occurs when rsp_valid && rsp_ready. rsp_ready goes 0 the cycle after the load and returns to 1 the cycle after the stop bit is driven.
- IDLE: the cycle where z_state=0 && line_in=0 is the start bit -> RX, bit counter = 0.
  - z_state=0 with line_in=1 is ignored; no start is taken.
- RX: each cycle shifts line_in into req_data, LSB first.
  - If z_state=1 before WIDTH bits are received: err pulse, req_data unchanged, -> IDLE.
  - After bit WIDTH-1: req_valid pulse the next cycle -> WAIT_REL.
- WAIT_REL: stay until z_state=1, then -> TURN with count = 0. No timeout.
- TURN: line_oe=0 for TURNAROUND cycles. If z_state=0 during TURN: err pulse -> IDLE, buffer kept.
  - At the end of TURN with the buffer full -> TX.
  - At the end of TURN with the buffer empty -> IDLE (silent NAK).
- TX: line_oe=1 for exactly 1+WIDTH+1 cycles: start bit 0, then data LSB first, then stop bit 1. Then line_oe=0, buffer emptied, -> IDLE.
- Collision: in TX, if line_in != line_out from the second driven cycle onward:
  - line_oe=0 next cycle, err pulse;
  - buffer kept (it is re-sent after the next request) -> IDLE.
- Simultaneous rsp_valid load during TURN: counts as buffer full if the load happens at or before the last TURN cycle.
- line_out=1 whenever line_oe=0.

Test Plan:
- Reset, then hold z_state=1 for 10 cycles -> line_oe=0, rsp_ready=1, busy=0, err=0.
- Load rsp 0x3C. Drive start plus 0xA5 LSB first (WIDTH=8), release -> req_valid pulse with req_data=0xA5; line_oe=0 for 2 cycles; then line_out drives 0, 0,0,1,1,1,1,0,0, 1 over 10 cycles; then line_oe=0 and rsp_ready=1.
- Same request with no response loaded -> req_valid pulse, line_oe stays 0, back to IDLE after the turnaround.
- Release z_state after 4 data bits -> err pulse, no req_valid, busy=0 next cycle, line_oe never 1.
- During TX of 0x3C, force line_in=0 on the stop-bit cycle -> line_oe=0 next cycle, err pulse, rsp_ready stays 0; the next full request re-sends 0x3C.
- Assert rst in the middle of TX -> line_oe=0 with no clock edge; after reset, rsp_ready=1 and state IDLE.
